// File: rtl/jedro_1_mem_arb_pkg.sv
// Shared types and helpers for the jedro_1 IFU/LSU memory arbiter.
package jedro_1_mem_arb_pkg;

   typedef enum logic [1:0] {OWN_NONE, OWN_IFU, OWN_LSU} owner_e;

   // Round-robin pointer encoding: which requester wins the next conflict.
   localparam logic RR_IFU = 1'b0;
   localparam logic RR_LSU = 1'b1;

   // True when a byte address falls inside a RAM of mem_words 32-bit words.
   function automatic logic in_range(input logic [63:0] addr, input logic [63:0] mem_words);
      return addr < (mem_words << 2);
   endfunction

endpackage

// File: rtl/jedro_1_arb_pick.sv
// Combinational winner selection between IFU and LSU.
// Build option JEDRO_1_ARB_ROUND_ROBIN_EN: strict alternation on conflicts
// (rr selects the preferred side). Default: LSU priority, IFU wins a
// conflict once the starvation counter has hit its limit.
module jedro_1_arb_pick
   import jedro_1_mem_arb_pkg::*;
(
   input  logic ifu_req,
   input  logic lsu_req,
   input  logic starve_hit,
   input  logic rr,
   output logic grant_ifu,
   output logic grant_lsu
);

`ifdef JEDRO_1_ARB_ROUND_ROBIN_EN
   logic unused_starve_hit;
   assign unused_starve_hit = starve_hit;

   // Conflicts go to the side rr points at; lone requests always win.
   always_comb begin
      grant_ifu = 1'b0;
      grant_lsu = 1'b0;
      if (ifu_req && lsu_req) begin
         grant_ifu = (rr == RR_IFU);
         grant_lsu = (rr == RR_LSU);
      end else begin
         grant_ifu = ifu_req;
         grant_lsu = lsu_req;
      end
   end
`else
   logic unused_rr;
   assign unused_rr = rr;

   // LSU wins conflicts unless the IFU has been starved long enough.
   always_comb begin
      grant_ifu = 1'b0;
      grant_lsu = 1'b0;
      if (ifu_req && lsu_req) begin
         grant_ifu = starve_hit;
         grant_lsu = !starve_hit;
      end else begin
         grant_ifu = ifu_req;
         grant_lsu = lsu_req;
      end
   end
`endif

endmodule

// File: rtl/jedro_1_mem_arbiter.sv
// Shares one single-port synchronous RAM between the jedro_1 instruction
// fetch unit and the load/store unit. One grant per cycle, response one
// cycle later routed to the owner recorded in owner_q.
// Build option: JEDRO_1_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// instead of LSU priority with an IFU starvation counter.
module jedro_1_mem_arbiter
   import jedro_1_mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 1024,
   parameter int STARVE_MAX = 4
)(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  ifu_req_i,
   input  logic [ADDR_WIDTH-1:0] ifu_addr_i,
   output logic                  ifu_gnt_o,
   output logic                  ifu_rvalid_o,
   output logic [DATA_WIDTH-1:0] ifu_rdata_o,
   output logic                  ifu_err_o,
   input  logic                  lsu_req_i,
   input  logic                  lsu_we_i,
   input  logic [3:0]            lsu_be_i,
   input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
   input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
   output logic                  lsu_gnt_o,
   output logic                  lsu_rvalid_o,
   output logic [DATA_WIDTH-1:0] lsu_rdata_o,
   output logic                  lsu_err_o,
   output logic                  mem_en_o,
   output logic [3:0]            mem_we_o,
   output logic [ADDR_WIDTH-3:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   owner_e owner_q, owner_d;
   logic   err_q, err_d;
   logic   wr_q, wr_d;
   logic   rr_q, rr_d;
   logic   starve_hit;
   logic   pick_ifu, pick_lsu;
   logic   gnt_ifu, gnt_lsu;
   logic   ifu_ok, lsu_ok;

   assign ifu_ok = in_range(64'(ifu_addr_i), 64'(MEM_WORDS));
   assign lsu_ok = in_range(64'(lsu_addr_i), 64'(MEM_WORDS));

   jedro_1_arb_pick u_pick (
      .ifu_req    (ifu_req_i),
      .lsu_req    (lsu_req_i),
      .starve_hit (starve_hit),
      .rr         (rr_q),
      .grant_ifu  (pick_ifu),
      .grant_lsu  (pick_lsu)
   );

   // Grants are suppressed while reset is held so nothing reaches the RAM.
   assign gnt_ifu   = pick_ifu && !rst_i;
   assign gnt_lsu   = pick_lsu && !rst_i;
   assign ifu_gnt_o = gnt_ifu;
   assign lsu_gnt_o = gnt_lsu;

   // Drive the RAM for the granted access and capture what its response needs.
   always_comb begin
      mem_en_o    = 1'b0;
      mem_we_o    = 4'b0000;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      owner_d     = OWN_NONE;
      err_d       = 1'b0;
      wr_d        = 1'b0;
      if (gnt_lsu) begin
         mem_en_o    = lsu_ok;
         mem_we_o    = (lsu_we_i && lsu_ok) ? lsu_be_i : 4'b0000;
         mem_addr_o  = lsu_addr_i[ADDR_WIDTH-1:2];
         mem_wdata_o = lsu_wdata_i;
         owner_d     = OWN_LSU;
         err_d       = !lsu_ok;
         wr_d        = lsu_we_i;
      end else if (gnt_ifu) begin
         mem_en_o    = ifu_ok;
         mem_addr_o  = ifu_addr_i[ADDR_WIDTH-1:2];
         owner_d     = OWN_IFU;
         err_d       = !ifu_ok;
      end
   end

   // Owner of the access in flight plus its error/write qualifiers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         owner_q <= OWN_NONE;
         err_q   <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         owner_q <= owner_d;
         err_q   <= err_d;
         wr_q    <= wr_d;
      end
   end

`ifdef JEDRO_1_ARB_ROUND_ROBIN_EN
   assign starve_hit = 1'b0;
   assign rr_d = (gnt_ifu && lsu_req_i) ? RR_LSU :
                 (gnt_lsu && ifu_req_i) ? RR_IFU : rr_q;
`else
   localparam int STARVE_W = $clog2(STARVE_MAX + 1);
   logic [STARVE_W-1:0] starve_cnt_q;

   assign starve_hit = (starve_cnt_q == STARVE_W'(STARVE_MAX));
   assign rr_d       = rr_q;

   // Count consecutive denied IFU cycles, saturating at the limit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         starve_cnt_q <= '0;
      else if (!ifu_req_i || gnt_ifu)
         starve_cnt_q <= '0;
      else if (!starve_hit)
         starve_cnt_q <= starve_cnt_q + 1'b1;
   end
`endif

   // Round-robin pointer; only moves on contested grants.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rr_q <= RR_IFU;
      else       rr_q <= rr_d;
   end

   // Writes and out-of-range accesses respond with zero data.
   assign ifu_rvalid_o = (owner_q == OWN_IFU);
   assign ifu_err_o    = ifu_rvalid_o && err_q;
   assign ifu_rdata_o  = (ifu_rvalid_o && !err_q) ? mem_rdata_i : '0;
   assign lsu_rvalid_o = (owner_q == OWN_LSU);
   assign lsu_err_o    = lsu_rvalid_o && err_q;
   assign lsu_rdata_o  = (lsu_rvalid_o && !err_q && !wr_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Directed bench for jedro_1_mem_arbiter with a behavioural 1024-word RAM.
module tb_jedro_1_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req;
   logic [31:0] ifu_addr;
   logic        ifu_gnt, ifu_rvalid, ifu_err;
   logic [31:0] ifu_rdata;
   logic        lsu_req, lsu_we;
   logic [3:0]  lsu_be;
   logic [31:0] lsu_addr, lsu_wdata;
   logic        lsu_gnt, lsu_rvalid, lsu_err;
   logic [31:0] lsu_rdata;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic [31:0] ram [0:1023];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   jedro_1_mem_arbiter dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .ifu_req_i    (ifu_req),
      .ifu_addr_i   (ifu_addr),
      .ifu_gnt_o    (ifu_gnt),
      .ifu_rvalid_o (ifu_rvalid),
      .ifu_rdata_o  (ifu_rdata),
      .ifu_err_o    (ifu_err),
      .lsu_req_i    (lsu_req),
      .lsu_we_i     (lsu_we),
      .lsu_be_i     (lsu_be),
      .lsu_addr_i   (lsu_addr),
      .lsu_wdata_i  (lsu_wdata),
      .lsu_gnt_o    (lsu_gnt),
      .lsu_rvalid_o (lsu_rvalid),
      .lsu_rdata_o  (lsu_rdata),
      .lsu_err_o    (lsu_err),
      .mem_en_o     (mem_en),
      .mem_we_o     (mem_we),
      .mem_addr_o   (mem_addr),
      .mem_wdata_o  (mem_wdata),
      .mem_rdata_i  (mem_rdata)
   );

   // Single-port synchronous RAM, read-before-write within the same access.
   always @(posedge clk) begin
      if (mem_en) begin
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) ram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
         mem_rdata <= ram[mem_addr[9:0]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] words [0:2];
   logic        exp_ifu;

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
      words[0] = 32'h00000413;
      words[1] = 32'h00100493;
      words[2] = 32'h00000013;
      for (int i = 0; i < 3; i++) ram[i] = words[i];

      rst = 1'b1;
      ifu_req = 1'b1; ifu_addr = 32'h10;
      lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'hF;
      lsu_addr = 32'h10; lsu_wdata = 32'h12345678;
      cyc();
      chk("rst_ifu_gnt",    32'(ifu_gnt), 32'h0);
      chk("rst_lsu_gnt",    32'(lsu_gnt), 32'h0);
      chk("rst_mem_en",     32'(mem_en), 32'h0);
      chk("rst_mem_we",     32'(mem_we), 32'h0);
      chk("rst_mem_addr",   32'(mem_addr), 32'h0);
      chk("rst_mem_wdata",  mem_wdata, 32'h0);
      chk("rst_rvalids",    32'({ifu_rvalid, lsu_rvalid, ifu_err, lsu_err}), 32'h0);
      chk("rst_rdatas",     ifu_rdata | lsu_rdata, 32'h0);

      // LSU read granted, then reset hits before its response
      rst = 1'b0; ifu_req = 1'b0; lsu_we = 1'b0;
      #1;
      chk("midrd_gnt",      32'(lsu_gnt), 32'h1);
      chk("midrd_mem_en",   32'(mem_en), 32'h1);
      chk("midrd_mem_addr", 32'(mem_addr), 32'h4);
      cyc();
      rst = 1'b1; lsu_req = 1'b0;
      #1;
      chk("midrd_rvalid_inrst", 32'(lsu_rvalid), 32'h0);
      cyc();
      chk("midrd_rvalid_late",  32'(lsu_rvalid), 32'h0);
      rst = 1'b0;
      cyc();
      chk("midrd_rvalid_after", 32'(lsu_rvalid), 32'h0);

      // IFU back-to-back fetches
      for (int i = 0; i < 3; i++) begin
         ifu_req = 1'b1; ifu_addr = 32'(4 * i);
         #1;
         chk("ifu_gnt",      32'(ifu_gnt), 32'h1);
         chk("ifu_mem_addr", 32'(mem_addr), 32'(i));
         cyc();
         chk("ifu_rvalid",   32'(ifu_rvalid), 32'h1);
         chk("ifu_rdata",    ifu_rdata, words[i]);
         chk("ifu_err",      32'(ifu_err), 32'h0);
      end
      ifu_req = 1'b0;
      #1;
      chk("ifu_idle_gnt", 32'(ifu_gnt), 32'h0);
      cyc();
      chk("ifu_idle_rvalid", 32'(ifu_rvalid), 32'h0);

      // LSU partial write then read-back
      lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'b0011;
      lsu_addr = 32'h100; lsu_wdata = 32'hDEADBEEF;
      #1;
      chk("wr_gnt",       32'(lsu_gnt), 32'h1);
      chk("wr_mem_we",    32'(mem_we), 32'h3);
      chk("wr_mem_en",    32'(mem_en), 32'h1);
      chk("wr_mem_addr",  32'(mem_addr), 32'h40);
      chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
      cyc();
      chk("wr_rvalid",    32'(lsu_rvalid), 32'h1);
      chk("wr_rdata",     lsu_rdata, 32'h0);
      lsu_we = 1'b0;
      #1;
      chk("rd_gnt",       32'(lsu_gnt), 32'h1);
      chk("rd_mem_we",    32'(mem_we), 32'h0);
      cyc();
      chk("rd_rvalid",    32'(lsu_rvalid), 32'h1);
      chk("rd_rdata",     lsu_rdata, 32'h0000BEEF);
      chk("rd_err",       32'(lsu_err), 32'h0);

      // Out-of-range LSU read
      lsu_addr = 32'h1000;
      #1;
      chk("oor_gnt",      32'(lsu_gnt), 32'h1);
      chk("oor_mem_en",   32'(mem_en), 32'h0);
      cyc();
      chk("oor_rvalid",   32'(lsu_rvalid), 32'h1);
      chk("oor_err",      32'(lsu_err), 32'h1);
      chk("oor_rdata",    lsu_rdata, 32'h0);
      lsu_req = 1'b0;
      cyc();

      // Continuous contention from a clean arbitration state
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h100;
      ifu_req = 1'b1; ifu_addr = 32'h4;
      for (int k = 0; k < 10; k++) begin
`ifdef JEDRO_1_ARB_ROUND_ROBIN_EN
         exp_ifu = (k % 2 == 0);
`else
         exp_ifu = (k % 5 == 4);
`endif
         #1;
         chk("cont_ifu_gnt", 32'(ifu_gnt), 32'(exp_ifu));
         chk("cont_lsu_gnt", 32'(lsu_gnt), 32'(!exp_ifu));
         cyc();
         chk("cont_ifu_rvalid", 32'(ifu_rvalid), 32'(exp_ifu));
         chk("cont_lsu_rvalid", 32'(lsu_rvalid), 32'(!exp_ifu));
         if (exp_ifu) chk("cont_ifu_rdata", ifu_rdata, 32'h00100493);
         else         chk("cont_lsu_rdata", lsu_rdata, 32'h0000BEEF);
      end
      lsu_req = 1'b0; ifu_req = 1'b0;
      cyc();
      chk("end_idle", 32'({ifu_rvalid, lsu_rvalid}), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
